bram_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port BRAM (12-bit address, 18-bit data) between N BCP engines, for example clause fetch, watch-list update and trail.
- Each requester issues reads and writes through a valid/ready port.
- The arbiter grants one access per cycle, registers the command onto the BRAM pins and routes read data back to the requester that issued it.
- Sits between the BCP engines and the bram instance.

---
 rtl/bram_arb_pkg.sv | 18 +
 rtl/bram_arbiter_rr.sv | 44 ++++
 rtl/bram_arbiter.sv | 137 +++++++++++++
 tb/tb_bram_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared constants, command record and FSM state type for the BRAM arbiter
package bram_arb_pkg;

    localparam int BRAM_AW = 12;
    localparam int BRAM_DW = 18;

    typedef struct packed {
        logic               write;
        logic [BRAM_AW-1:0] addr;
        logic [BRAM_DW-1:0] wdata;
    } cmd_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/bram_arbiter_rr.sv
// rtl/bram_arbiter_rr.sv - round-robin one-hot grant with pointer advanced on accept
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] gidx;
    logic          found;

    // first valid requester after the pointer, wrapping modulo N
    always_comb begin
        grant = '0;
        gidx  = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (cand == PW'(N - 1)) ? '0 : cand + PW'(1);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

    // a grant is always a handshake (grant implies valid), so the pointer follows every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PW'(N - 1);
        end else if (|grant) begin
            ptr <= gidx;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin BRAM port sharer; optional power-up clear under BRAM_ARB_CLEAR_EN
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N      = 4,
    parameter int AW     = BRAM_AW,
    parameter int DW     = BRAM_DW,
    parameter int RD_LAT = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N-1:0]    REQ_VALID,
    input  logic [N-1:0]    REQ_WRITE,
    input  logic [N*AW-1:0] REQ_ADDR,
    input  logic [N*DW-1:0] REQ_WDATA,
    output logic [N-1:0]    REQ_READY,
    output logic [N-1:0]    RSP_VALID,
    output logic [DW-1:0]   RSP_DATA,
    output logic            INIT_DONE,
    output logic            BRAM_EN,
    output logic            BRAM_READ,
    output logic            BRAM_WRITE,
    output logic [AW-1:0]   BRAM_ADDR,
    output logic [DW-1:0]   BRAM_DIN,
    input  logic [DW-1:0]   BRAM_DOUT
);

    localparam int D = 1 + RD_LAT;

    state_t        state;
    logic          run;
    logic [N-1:0]  grant;
    logic          accept;
    logic          acc_write;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic [N-1:0]  tag_pipe [D];

`ifdef BRAM_ARB_CLEAR_EN
    logic [AW:0]   clr_cnt;
`endif

    assign run = (state == ST_RUN) && INIT_DONE;

    rr_arbiter #(.N(N)) u_rr (
        .clk    (CLK),
        .rst    (RST),
        .enable (run),
        .req    (REQ_VALID),
        .grant  (grant)
    );

    assign REQ_READY = grant;
    assign accept    = |grant;

    // select the granted requester's command slice
    always_comb begin
        acc_write = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                acc_write = REQ_WRITE[i];
                acc_addr  = REQ_ADDR[i*AW +: AW];
                acc_wdata = REQ_WDATA[i*DW +: DW];
            end
        end
    end

    // control FSM: optional clear sweep, then registered issue of accepted commands
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
`ifdef BRAM_ARB_CLEAR_EN
            state   <= ST_CLEAR;
            clr_cnt <= '0;
`else
            state   <= ST_RUN;
`endif
            INIT_DONE  <= 1'b0;
            BRAM_EN    <= 1'b0;
            BRAM_READ  <= 1'b0;
            BRAM_WRITE <= 1'b0;
            BRAM_ADDR  <= '0;
            BRAM_DIN   <= '0;
        end else begin
            case (state)
`ifdef BRAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    // the top counter bit marks that every address has been written
                    if (clr_cnt[AW]) begin
                        state      <= ST_RUN;
                        INIT_DONE  <= 1'b1;
                        BRAM_EN    <= 1'b0;
                        BRAM_WRITE <= 1'b0;
                        BRAM_READ  <= 1'b0;
                    end else begin
                        BRAM_EN    <= 1'b1;
                        BRAM_WRITE <= 1'b1;
                        BRAM_READ  <= 1'b0;
                        BRAM_ADDR  <= clr_cnt[AW-1:0];
                        BRAM_DIN   <= '0;
                        clr_cnt    <= clr_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    INIT_DONE  <= 1'b1;
                    BRAM_EN    <= accept;
                    BRAM_READ  <= accept & ~acc_write;
                    BRAM_WRITE <= accept & acc_write;
                    if (accept) begin
                        BRAM_ADDR <= acc_addr;
                        BRAM_DIN  <= acc_wdata;
                    end
                end
            endcase
        end
    end

    // read tags ride alongside the BRAM latency; writes push an empty tag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < D; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= (accept && !acc_write) ? grant : '0;
            for (int k = 1; k < D; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign RSP_VALID = tag_pipe[D-1];
    assign RSP_DATA  = (|tag_pipe[D-1]) ? BRAM_DOUT : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter with BRAM model and reference scoreboard
module tb_bram_arbiter;
    import bram_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 18;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [N-1:0]    REQ_VALID;
    logic [N-1:0]    REQ_WRITE;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N*DW-1:0] REQ_WDATA;
    logic [N-1:0]    REQ_READY;
    logic [N-1:0]    RSP_VALID;
    logic [DW-1:0]   RSP_DATA;
    logic            INIT_DONE;
    logic            BRAM_EN;
    logic            BRAM_READ;
    logic            BRAM_WRITE;
    logic [AW-1:0]   BRAM_ADDR;
    logic [DW-1:0]   BRAM_DIN;
    logic [DW-1:0]   BRAM_DOUT;

    always #5 CLK = ~CLK;

    bram_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ_VALID  (REQ_VALID),
        .REQ_WRITE  (REQ_WRITE),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .REQ_READY  (REQ_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_DATA   (RSP_DATA),
        .INIT_DONE  (INIT_DONE),
        .BRAM_EN    (BRAM_EN),
        .BRAM_READ  (BRAM_READ),
        .BRAM_WRITE (BRAM_WRITE),
        .BRAM_ADDR  (BRAM_ADDR),
        .BRAM_DIN   (BRAM_DIN),
        .BRAM_DOUT  (BRAM_DOUT)
    );

    // single-port BRAM, one cycle read latency
    logic [DW-1:0] mem [1<<AW];
    always @(posedge CLK) begin
        if (BRAM_EN) begin
            if (BRAM_WRITE) mem[BRAM_ADDR] <= BRAM_DIN;
            if (BRAM_READ)  BRAM_DOUT <= mem[BRAM_ADDR];
        end
    end

    // requester drive
    logic [N-1:0] valid;
    cmd_t         cmd [N];
    assign REQ_VALID = valid;
    always_comb begin
        REQ_WRITE = '0;
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        for (int i = 0; i < N; i++) begin
            REQ_WRITE[i]         = cmd[i].write;
            REQ_ADDR[i*AW +: AW] = cmd[i].addr;
            REQ_WDATA[i*DW +: DW] = cmd[i].wdata;
        end
    end

    // reference model state
    typedef struct {
        int            due;
        logic [N-1:0]  tag;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] shadow [1<<AW];
    rsp_t          rq [$];
    int            last;
    int            cyc;
    logic          prev_acc;
    logic          prev_wr;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_din;
    logic [N-1:0]  last_eg;
    logic [N-1:0]  obs_ready;
    logic [N-1:0]  obs_rv;
    logic [DW-1:0] obs_rd;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd[i].write = w;
        cmd[i].addr  = a;
        cmd[i].wdata = d;
    endtask

    // one clock: check outputs against the model at the negedge, then advance the model
    task automatic do_cycle;
        logic [N-1:0] eg;
        @(negedge CLK);
        eg        = exp_grant(valid);
        last_eg   = eg;
        obs_ready = REQ_READY;
        obs_rv    = RSP_VALID;
        obs_rd    = RSP_DATA;
        check("ready", REQ_READY, eg);
        check("bram_en", BRAM_EN, prev_acc);
        check("bram_write", BRAM_WRITE, prev_acc & prev_wr);
        check("bram_read", BRAM_READ, prev_acc & ~prev_wr);
        if (prev_acc) check("bram_addr", BRAM_ADDR, prev_addr);
        if (prev_acc && prev_wr) check("bram_din", BRAM_DIN, prev_din);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("rsp_valid", RSP_VALID, rq[0].tag);
            check("rsp_data", RSP_DATA, rq[0].data);
            void'(rq.pop_front());
        end else begin
            check("rsp_idle", RSP_VALID, '0);
        end
        prev_acc = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (eg[i]) begin
                last      = i;
                prev_acc  = 1'b1;
                prev_wr   = cmd[i].write;
                prev_addr = cmd[i].addr;
                prev_din  = cmd[i].wdata;
                if (cmd[i].write) shadow[cmd[i].addr] = cmd[i].wdata;
                else rq.push_back('{due: cyc + 2, tag: eg, data: shadow[cmd[i].addr]});
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic apply_reset;
        RST   = 1'b1;
        valid = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("rst_ready", REQ_READY, '0);
            check("rst_rsp_valid", RSP_VALID, '0);
            check("rst_rsp_data", RSP_DATA, '0);
            check("rst_init_done", INIT_DONE, 0);
            check("rst_bram_en", BRAM_EN, 0);
            check("rst_bram_read", BRAM_READ, 0);
            check("rst_bram_write", BRAM_WRITE, 0);
            check("rst_bram_addr", BRAM_ADDR, 0);
            check("rst_bram_din", BRAM_DIN, 0);
        end
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        last     = N - 1;
        prev_acc = 1'b0;
        rq.delete();
        check("init_done_release", INIT_DONE, 0);
`ifdef BRAM_ARB_CLEAR_EN
        for (int k = 1; k <= (1 << AW); k++) begin
            @(posedge CLK);
            #1;
            check("clr_write", BRAM_WRITE, 1);
            check("clr_addr", BRAM_ADDR, k - 1);
            check("clr_din", BRAM_DIN, 0);
            check("clr_init_done", INIT_DONE, 0);
            check("clr_ready", REQ_READY, '0);
            if (k == (1 << AW)) valid = '0;
        end
        for (int a = 0; a < (1 << AW); a++) shadow[a] = '0;
        @(posedge CLK);
        #1;
        check("init_done_4097", INIT_DONE, 1);
        check("clr_end_en", BRAM_EN, 0);
`else
        valid = '0;
        @(posedge CLK);
        #1;
        check("init_done_first_edge", INIT_DONE, 1);
`endif
        cyc++;
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] exp;
    } vec_t;

    vec_t         tbl [15];
    logic [N-1:0] pending;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
`ifdef BRAM_ARB_CLEAR_EN
            mem[a] = DW'(a * 7 + 5);
`else
            mem[a] = '0;
`endif
            shadow[a] = '0;
        end
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, '0, '0);
        valid = '0;
        cyc   = 0;
        last  = N - 1;
        prev_acc = 1'b0;
        prev_wr  = 1'b0;
        prev_addr = '0;
        prev_din  = '0;
        pending  = '0;

        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b1111, 4'b0010};
        tbl[6]  = '{4'b1111, 4'b0100};
        tbl[7]  = '{4'b1111, 4'b1000};
        tbl[8]  = '{4'b0000, 4'b0000};
        tbl[9]  = '{4'b1010, 4'b0010};
        tbl[10] = '{4'b1010, 4'b1000};
        tbl[11] = '{4'b0110, 4'b0010};
        tbl[12] = '{4'b0001, 4'b0001};
        tbl[13] = '{4'b1001, 4'b1000};
        tbl[14] = '{4'b1001, 4'b0001};

        #1;
        apply_reset();

        // arbitration table, all writes
        for (int r = 0; r < 15; r++) begin
            for (int i = 0; i < N; i++) set_cmd(i, 1'b1, AW'(12'h300 + r * 4 + i), DW'(r * 16 + i + 1));
            valid = tbl[r].valid;
            do_cycle();
            check("tbl_ready", obs_ready, tbl[r].exp);
        end
        valid = '0;
        do_cycle();

        // read of a cleared location
        set_cmd(0, 1'b0, 12'h7FF, '0);
        valid = 4'b0001;
        do_cycle();
        valid = '0;
        do_cycle();
        do_cycle();
        check("read_7ff_valid", obs_rv, 4'b0001);
        check("read_7ff_data", obs_rd, 0);

        // write then read back, exact two-cycle latency
        set_cmd(0, 1'b1, 12'h123, 18'h2ABCD);
        valid = 4'b0001;
        do_cycle();
        set_cmd(0, 1'b0, 12'h123, '0);
        do_cycle();
        valid = '0;
        do_cycle();
        check("wr_rd_early", obs_rv, 4'b0000);
        do_cycle();
        check("wr_rd_valid", obs_rv, 4'b0001);
        check("wr_rd_data", obs_rd, 18'h2ABCD);

        // back-to-back reads from two requesters
        set_cmd(0, 1'b1, 12'h010, 18'h00011);
        valid = 4'b0001;
        do_cycle();
        set_cmd(0, 1'b1, 12'h020, 18'h00022);
        do_cycle();
        set_cmd(1, 1'b0, 12'h010, '0);
        set_cmd(2, 1'b0, 12'h020, '0);
        valid = 4'b0110;
        do_cycle();
        check("b2b_grant1", obs_ready, 4'b0010);
        valid = 4'b0100;
        do_cycle();
        check("b2b_grant2", obs_ready, 4'b0100);
        valid = '0;
        do_cycle();
        check("b2b_rsp1_valid", obs_rv, 4'b0010);
        check("b2b_rsp1_data", obs_rd, 18'h00011);
        do_cycle();
        check("b2b_rsp2_valid", obs_rv, 4'b0100);
        check("b2b_rsp2_data", obs_rd, 18'h00022);

        // same-address hazard, write granted first
        set_cmd(3, 1'b1, 12'h055, 18'h00001);
        valid = 4'b1000;
        do_cycle();
        set_cmd(0, 1'b1, 12'h055, 18'h3FFFF);
        set_cmd(1, 1'b0, 12'h055, '0);
        valid = 4'b0011;
        do_cycle();
        check("haz_a_first", obs_ready, 4'b0001);
        valid = 4'b0010;
        do_cycle();
        valid = '0;
        do_cycle();
        do_cycle();
        check("haz_a_valid", obs_rv, 4'b0010);
        check("haz_a_data", obs_rd, 18'h3FFFF);

        // same-address hazard, read granted first
        set_cmd(0, 1'b1, 12'h055, 18'h00001);
        valid = 4'b0001;
        do_cycle();
        set_cmd(0, 1'b1, 12'h055, 18'h3FFFF);
        valid = 4'b0011;
        do_cycle();
        check("haz_b_first", obs_ready, 4'b0010);
        valid = 4'b0001;
        do_cycle();
        valid = '0;
        do_cycle();
        check("haz_b_valid", obs_rv, 4'b0010);
        check("haz_b_data", obs_rd, 18'h00001);

        // randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(1, 0) == 1) begin
                    set_cmd(i, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), DW'($urandom));
                    pending[i] = 1'b1;
                end else if (pending[i] && $urandom_range(15, 0) == 0) begin
                    pending[i] = 1'b0;
                end
            end
            valid = pending;
            do_cycle();
            pending = pending & ~last_eg;
        end
        valid = '0;
        for (int k = 0; k < 3; k++) do_cycle();
        check("rsp_queue_drained", rq.size(), 0);

        // reset one cycle after a read accept discards the response
        set_cmd(0, 1'b0, 12'h123, '0);
        valid = 4'b0001;
        do_cycle();
        apply_reset();
        valid = '1;
        do_cycle();
        check("post_rst_grant", obs_ready, 4'b0001);
        valid = '0;
        for (int k = 0; k < 3; k++) do_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
